enemy_hit_detector: RTL and testbench

//   Return path to the enemy controller: consumes enemy plane coordinates and the

---
 rtl/enemy_hit_detector.sv | 90 +++++++++
 tb/tb_enemy_hit_detector.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/enemy_hit_detector.sv
// enemy_hit_detector: scans snapshotted enemy slots one per clock and reports the lowest-index bullet hit
module enemy_hit_detector #(
    parameter int NUM_PLANES = 10,
    parameter int COORD_W    = 8,
    parameter int SPRITE_W   = 5,
    parameter int SPRITE_H   = 5
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            check_req,
    input  logic                            bullet_valid,
    input  logic [COORD_W-1:0]              bullet_x,
    input  logic [COORD_W-1:0]              bullet_y,
    input  logic [NUM_PLANES-1:0]           enemy_active,
    input  logic [NUM_PLANES*COORD_W-1:0]   enemy_x,
    input  logic [NUM_PLANES*COORD_W-1:0]   enemy_y,
    output logic                            busy,
    output logic                            done,
    output logic                            hit,
    output logic [NUM_PLANES-1:0]           destroyed,
    output logic                            bullet_clear,
    output logic [7:0]                      hit_count
);
    typedef enum logic [1:0] {IDLE, SCAN, REPORT} state_t;
    localparam int IW = NUM_PLANES > 1 ? $clog2(NUM_PLANES) : 1;
    state_t state, state_nx;
    logic [IW-1:0] idx, hit_idx, hit_idx_nx;
    logic found, found_nx, snap_valid, slot_hit, last, report_nx;
    logic [COORD_W-1:0] snap_bx, snap_by;
    logic [NUM_PLANES-1:0] snap_active;
    logic [NUM_PLANES-1:0][COORD_W-1:0] snap_x, snap_y;
    logic [COORD_W:0] x_hi, y_hi;
    // sprite extents are one bit wider so sprites near the right/bottom edge never wrap
    always_comb begin
        x_hi = {1'b0, snap_x[idx]} + (COORD_W+1)'(SPRITE_W - 1);
        y_hi = {1'b0, snap_y[idx]} + (COORD_W+1)'(SPRITE_H - 1);
        slot_hit = state == SCAN && snap_valid && snap_active[idx] && !found &&
                   snap_bx >= snap_x[idx] && {1'b0, snap_bx} <= x_hi &&
                   snap_by >= snap_y[idx] && {1'b0, snap_by} <= y_hi;
        last = idx == IW'(NUM_PLANES - 1);
        found_nx = found || slot_hit;
        hit_idx_nx = slot_hit ? idx : hit_idx;
        report_nx = state == SCAN && last;
        state_nx = state == IDLE ? (check_req ? SCAN : IDLE) :
                   state == SCAN ? (last ? REPORT : SCAN) : IDLE;
    end
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else state <= state_nx;
    end
    always_ff @(posedge clk) begin
        if (state == IDLE && check_req) begin
            snap_valid <= bullet_valid;
            snap_bx <= bullet_x;
            snap_by <= bullet_y;
            snap_active <= enemy_active;
            snap_x <= enemy_x;
            snap_y <= enemy_y;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            busy <= 1'b0;
            done <= 1'b0;
            hit <= 1'b0;
            destroyed <= '0;
            bullet_clear <= 1'b0;
            hit_count <= 8'd0;
            found <= 1'b0;
            idx <= '0;
            hit_idx <= '0;
        end else begin
            busy <= state_nx != IDLE;
            done <= report_nx;
            hit <= report_nx && found_nx;
            bullet_clear <= report_nx && found_nx;
            destroyed <= report_nx && found_nx ? NUM_PLANES'(1) << hit_idx_nx : '0;
            if (report_nx && found_nx && hit_count != 8'hFF) hit_count <= hit_count + 8'd1;
            if (state == IDLE && check_req) begin
                found <= 1'b0;
                idx <= '0;
            end
            if (state == SCAN) begin
                idx <= idx + 1'b1;
                found <= found_nx;
                hit_idx <= hit_idx_nx;
            end
        end
    end
endmodule

// File: tb/tb_enemy_hit_detector.sv
// tb_enemy_hit_detector: directed checks against a timing/geometry model of the hit detector
module tb_enemy_hit_detector;
    localparam int NP = 10;
    logic clk = 1'b0, reset = 1'b1, check_req = 1'b0, bullet_valid = 1'b0;
    logic [7:0] bullet_x = '0, bullet_y = '0;
    logic [NP-1:0] enemy_active = '0;
    logic [NP*8-1:0] enemy_x = '0, enemy_y = '0;
    logic busy, done, hit, bullet_clear;
    logic [NP-1:0] destroyed;
    logic [7:0] hit_count;
    int vectors = 0, miscompares = 0;
    bit ready = 0, m_act = 0;
    int m_c = 0, m_res = -1, m_cnt = 0;

    enemy_hit_detector dut (
        .clk(clk), .reset(reset), .check_req(check_req), .bullet_valid(bullet_valid),
        .bullet_x(bullet_x), .bullet_y(bullet_y), .enemy_active(enemy_active),
        .enemy_x(enemy_x), .enemy_y(enemy_y), .busy(busy), .done(done), .hit(hit),
        .destroyed(destroyed), .bullet_clear(bullet_clear), .hit_count(hit_count)
    );

    always #5 clk = ~clk;

    function automatic int find_hit();
        for (int i = 0; i < NP; i++) begin
            int ex = int'(enemy_x[i*8 +: 8]);
            int ey = int'(enemy_y[i*8 +: 8]);
            int bx = int'(bullet_x);
            int by = int'(bullet_y);
            if (bullet_valid && enemy_active[i] && bx >= ex && bx <= ex + 4 && by >= ey && by <= ey + 4)
                return i;
        end
        return -1;
    endfunction

    // model: a check spans NP+1 cycles after acceptance; result fixed at acceptance
    always @(posedge clk) begin
        ready = 1;
        if (reset) begin
            m_act = 0;
            m_cnt = 0;
        end else if (m_act) begin
            m_c++;
            if (m_c == NP && m_res >= 0 && m_cnt < 255) m_cnt++;
            if (m_c > NP) m_act = 0;
        end else if (check_req) begin
            m_act = 1;
            m_c = 0;
            m_res = find_hit();
        end
    end

    always @(negedge clk) begin
        if (ready) begin
            logic e_done, e_hit;
            logic [NP-1:0] e_des;
            e_done = m_act && m_c == NP;
            e_hit = e_done && m_res >= 0;
            e_des = e_hit ? NP'(1) << m_res : '0;
            vectors++;
            if (busy !== m_act || done !== e_done || hit !== e_hit || bullet_clear !== e_hit ||
                destroyed !== e_des || hit_count !== 8'(m_cnt)) begin
                miscompares++;
                $display("FAIL cycle@%0t got busy=%b done=%b hit=%b clr=%b des=%b cnt=%0d exp busy=%b done=%b hit=%b clr=%b des=%b cnt=%0d",
                         $time, busy, done, hit, bullet_clear, destroyed, hit_count,
                         m_act, e_done, e_hit, e_hit, e_des, m_cnt);
            end
        end
    end

    task automatic set_slot(input int i, input int x, input int y);
        enemy_x[i*8 +: 8] = 8'(x);
        enemy_y[i*8 +: 8] = 8'(y);
        enemy_active[i] = 1'b1;
    endtask

    task automatic set_bullet(input int x, input int y);
        bullet_valid = 1'b1;
        bullet_x = 8'(x);
        bullet_y = 8'(y);
    endtask

    task automatic pulse_req();
        @(negedge clk) check_req = 1'b1;
        @(negedge clk) check_req = 1'b0;
    endtask

    task automatic wait_done(input string name, input logic [NP-1:0] e_des, input int e_cnt);
        int n = 0;
        while (done !== 1'b1 && n < 30) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (done !== 1'b1 || destroyed !== e_des || hit_count !== 8'(e_cnt) || hit !== (e_des != 0)) begin
            miscompares++;
            $display("FAIL %s got done=%b hit=%b des=%b cnt=%0d exp done=1 des=%b cnt=%0d",
                     name, done, hit, destroyed, hit_count, e_des, e_cnt);
        end
        @(negedge clk);
    endtask

    task automatic check_now(input string name, input logic [NP-1:0] e_des, input int e_cnt, input logic e_busy);
        vectors++;
        if (destroyed !== e_des || hit_count !== 8'(e_cnt) || busy !== e_busy || done !== 1'b0) begin
            miscompares++;
            $display("FAIL %s got busy=%b done=%b des=%b cnt=%0d exp busy=%b done=0 des=%b cnt=%0d",
                     name, busy, done, destroyed, hit_count, e_busy, e_des, e_cnt);
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check_now("reset_state", '0, 0, 1'b0);
        reset = 1'b0;
        set_slot(3, 10, 28);
        set_bullet(12, 30);
        pulse_req();
        repeat (9) @(negedge clk);
        vectors++;
        if (done !== 1'b0) begin
            miscompares++;
            $display("FAIL early_done got done=%b exp done=0", done);
        end
        @(negedge clk);
        vectors++;
        if (done !== 1'b1 || bullet_clear !== 1'b1) begin
            miscompares++;
            $display("FAIL latency got done=%b clr=%b exp done=1 clr=1", done, bullet_clear);
        end
        wait_done("t1_basic", 10'b0000001000, 1);
        enemy_active = '0;
        set_slot(2, 38, 37);
        set_slot(5, 40, 40);
        set_bullet(40, 40);
        pulse_req();
        wait_done("t2_lowest", 10'b0000000100, 2);
        enemy_active = '0;
        set_slot(3, 10, 28);
        set_bullet(14, 32);
        pulse_req();
        wait_done("t3_far_edge", 10'b0000001000, 3);
        set_bullet(15, 28);
        pulse_req();
        wait_done("t3_outside", '0, 3);
        enemy_active = '0;
        set_slot(7, 254, 0);
        set_bullet(2, 2);
        pulse_req();
        wait_done("t4_nowrap", '0, 3);
        set_bullet(255, 3);
        pulse_req();
        wait_done("t4_right", 10'b0010000000, 4);
        enemy_active = '0;
        set_slot(3, 10, 28);
        set_bullet(12, 30);
        pulse_req();
        @(negedge clk);
        @(negedge clk) enemy_x[3*8 +: 8] = 8'd100;
        check_req = 1'b1;
        @(negedge clk) check_req = 1'b0;
        wait_done("t5_snapshot", 10'b0000001000, 5);
        repeat (15) @(negedge clk);
        check_now("t5_no_second", '0, 5, 1'b0);
        set_bullet(100, 30);
        bullet_valid = 1'b0;
        pulse_req();
        wait_done("bullet_invalid", '0, 5);
        bullet_valid = 1'b1;
        enemy_active = '0;
        enemy_y[3*8 +: 8] = 8'd28;
        pulse_req();
        wait_done("inactive", '0, 5);
        enemy_active[3] = 1'b1;
        for (int k = 6; k <= 257; k++) begin
            pulse_req();
            wait_done("saturate", 10'b0000001000, k > 255 ? 255 : k);
        end
        pulse_req();
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_now("reset_abort", '0, 0, 1'b0);
        reset = 1'b0;
        repeat (15) @(negedge clk);
        check_now("after_abort", '0, 0, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
